video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (pixel enable, syncs, blanks, x/y).
// Modes: 0=320x240p, 1=256x224p, 2=320x288p, 3=640x480 (double pixel rate).
// Optional feature macro: VIDEO_TIMING_GEN_INTERLACE_EN -- mode 3 becomes
// interlaced: field toggles per frame, field 1 has 263 lines and its v_sync
// edges sit at mid-line (x = H_TOTAL/2).
module video_timing_gen #(
  parameter int CE_DIV = 4,
  parameter int H_BITS = 10,
  parameter int V_BITS = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  output logic              ce_pix,
  output logic              h_sync,
  output logic              v_sync,
  output logic              h_blank,
  output logic              v_blank,
  output logic              de,
  output logic              field,
  output logic [H_BITS-1:0] x,
  output logic [V_BITS-1:0] y,
  output logic              line_start,
  output logic              frame_start
);
  localparam int            DW    = $clog2(CE_DIV) + 1;
  localparam logic [DW-1:0] DIV_P = DW'(CE_DIV - 1);
  localparam logic [DW-1:0] DIV_I = DW'(CE_DIV / 2 - 1);

  logic [1:0]        mode_q;   // mode governing the current frame
  logic [DW-1:0]     div_q;
  logic              first_q;  // next ce is the first one after reset
  logic              wrap_q;   // currently presented pixel is the last of the frame
  logic              fld_q;    // field for the upcoming frame

  logic [H_BITS-1:0] h_act, h_ss, h_se, h_tot, vs_x, nx;
  logic [V_BITS-1:0] v_act, v_ss, v_se, v_tot, ny;
  logic              tick, new_frame, fld_nxt;

  // Timing table for the latched mode, as active end / sync start / sync end / total.
  always_comb begin
    h_act = H_BITS'(320); h_ss = H_BITS'(336); h_se = H_BITS'(368); h_tot = H_BITS'(426);
    v_act = V_BITS'(240); v_ss = V_BITS'(243); v_se = V_BITS'(246); v_tot = V_BITS'(262);
    case (mode_q)
      2'd1: begin
        h_act = H_BITS'(256); h_ss = H_BITS'(268); h_se = H_BITS'(294); h_tot = H_BITS'(341);
        v_act = V_BITS'(224); v_ss = V_BITS'(235); v_se = V_BITS'(238);
      end
      2'd2: begin
        v_act = V_BITS'(288); v_ss = V_BITS'(290); v_se = V_BITS'(293); v_tot = V_BITS'(312);
      end
      2'd3: begin
        h_act = H_BITS'(640); h_ss = H_BITS'(672); h_se = H_BITS'(736); h_tot = H_BITS'(852);
      end
      default: ;
    endcase
    vs_x = h_ss;
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
    if (mode_q == 2'd3 && field) begin
      v_tot = V_BITS'(263);
      vs_x  = h_tot >> 1;
    end
`endif
  end

  // Divider tick, next raster position and the field for the next frame.
  always_comb begin
    tick      = (div_q >= ((mode_q == 2'd3) ? DIV_I : DIV_P));
    new_frame = first_q | wrap_q;
    nx        = x + 1'b1;
    ny        = y;
    if (new_frame) begin
      nx = '0;
      ny = '0;
    end else if (x == h_tot - 1'b1) begin
      nx = '0;
      ny = y + 1'b1;
    end
`ifdef VIDEO_TIMING_GEN_INTERLACE_EN
    // A frame entering mode 3 from another mode always starts on the even field.
    fld_nxt = (mode == 2'd3 && mode_q == 2'd3) ? ~field : 1'b0;
`else
    fld_nxt = 1'b0;
`endif
  end

  // Divider, mode/field latching and registered raster outputs.
  // The divider sits at 0 on every ce cycle, so a period change latched at the
  // frame wrap counts the first new-frame ce from a clean restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      mode_q      <= 2'd0;
      first_q     <= 1'b1;
      wrap_q      <= 1'b0;
      fld_q       <= 1'b0;
      ce_pix      <= 1'b0;
      h_sync      <= 1'b0;
      v_sync      <= 1'b0;
      h_blank     <= 1'b0;
      v_blank     <= 1'b0;
      de          <= 1'b0;
      field       <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (ce_pix && wrap_q) begin
        mode_q <= mode;
        fld_q  <= fld_nxt;
      end
      if (tick) begin
        div_q       <= '0;
        ce_pix      <= 1'b1;
        x           <= nx;
        y           <= ny;
        h_blank     <= (nx >= h_act);
        v_blank     <= (ny >= v_act);
        de          <= (nx < h_act) && (ny < v_act);
        h_sync      <= (nx >= h_ss) && (nx < h_se);
        v_sync      <= ((ny > v_ss) || ((ny == v_ss) && (nx >= vs_x))) &&
                       ((ny < v_se) || ((ny == v_se) && (nx < vs_x)));
        line_start  <= (nx == '0);
        frame_start <= (nx == '0) && (ny == '0);
        wrap_q      <= (nx == h_tot - 1'b1) && (ny == v_tot - 1'b1);
        // With a one-clk period the wrap latch and the new-frame ce share an edge.
        if (new_frame) field <= (ce_pix && wrap_q) ? fld_nxt : fld_q;
        if (first_q) begin
          first_q <= 1'b0;
          mode_q  <= mode;
        end
      end else begin
        div_q       <= div_q + 1'b1;
        ce_pix      <= 1'b0;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end
endmodule
